// File: rtl/mole_game_core.sv
// mole_game_core: N-channel reaction-game timing core with synchronised, debounced buttons.
// Optional build macro RAND_OFF_EN: LFSR-randomised light-down times (fixed times otherwise).
module mole_game_core #(
    parameter int NUM_CH     = 4,
    parameter int ON_CYCLES  = 50_000_000,
    parameter int OFF_BASE   = 250_000_000,
    parameter int OFF_STEP   = 50_000_000,
    parameter int MISS_LIMIT = 10,
    parameter int SCORE_W    = 16,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_CH-1:0]  btn_n,
    input  logic               start_n,
    output logic [NUM_CH-1:0]  mole,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss,
    output logic               in_game,
    output logic               game_over,
    output logic [5:0]         led_phase
);
    localparam int NIN     = NUM_CH + 1;
    localparam int OFF_MAX = OFF_BASE + (NUM_CH - 1) * OFF_STEP;
    localparam int T_MAX   = (OFF_MAX > ON_CYCLES) ? OFF_MAX : ON_CYCLES;
    localparam int TW      = $clog2(T_MAX + 1);
    localparam int DW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int CW      = $clog2(NUM_CH + 1);
    localparam int SW2     = SCORE_W + CW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [CW-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int j = 0; j < NUM_CH; j++) c = c + CW'(v[j]);
        return c;
    endfunction

    function automatic logic [5:0] led_onehot(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        r = s % SCORE_W'(6);
        return 6'b000001 << r[2:0];
    endfunction

    logic [1:0]         rst_sync_q;
    logic               rst_n_s;
    logic [NIN-1:0]     raw_s, sync1_q, sync2_q, deb_q, deb_dly_q, press_s;
    logic [DW-1:0]      deb_cnt_q [NIN];
    logic [NUM_CH-1:0]  btn_press_s, hit_s, tout_s, rise_s;
    logic               start_press_s;
    logic [TW-1:0]      timer_q [NUM_CH];
    logic [TW-1:0]      off_last_s [NUM_CH];
    logic [SW2-1:0]     score_sum_s, miss_sum_s;
    logic [SCORE_W-1:0] score_d, miss_d;
    state_t             state_q;
    logic [NUM_CH-1:0]  mole_q;
    logic [SCORE_W-1:0] score_q, miss_q;
    logic               in_game_q, game_over_q;
    logic [5:0]         led_q;

    // Reset asserts asynchronously but is released on a clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_s = rst_sync_q[1];

    assign raw_s = {start_n, btn_n};

    // Two-flop synchroniser followed by a stable-for-DEB_CYCLES debouncer per input
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            deb_q     <= '1;
            deb_dly_q <= '1;
            for (int k = 0; k < NIN; k++) deb_cnt_q[k] <= '0;
        end else begin
            sync1_q   <= raw_s;
            sync2_q   <= sync1_q;
            deb_dly_q <= deb_q;
            for (int k = 0; k < NIN; k++) begin
                if (sync2_q[k] != deb_q[k]) begin
                    if (deb_cnt_q[k] == DW'(DEB_CYCLES - 1)) begin
                        deb_q[k]     <= sync2_q[k];
                        deb_cnt_q[k] <= '0;
                    end else begin
                        deb_cnt_q[k] <= deb_cnt_q[k] + DW'(1);
                    end
                end else begin
                    deb_cnt_q[k] <= '0;
                end
            end
        end
    end

    assign press_s       = deb_dly_q & ~deb_q;
    assign btn_press_s   = press_s[NUM_CH-1:0];
    assign start_press_s = press_s[NUM_CH];

`ifdef RAND_OFF_EN
    logic [15:0]       lfsr_q;
    logic [NUM_CH-1:0] enter_s;
    logic [TW-1:0]     off_q [NUM_CH];
    logic [TW-1:0]     rand_last_s [NUM_CH];

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    // Lowest entering channel draws the raw LFSR value, higher ones a rotated copy
    always_comb begin
        logic        seen;
        logic [15:0] rot;
        longint      draw;
        seen    = 1'b0;
        rot     = 16'h0000;
        draw    = 64'sd0;
        enter_s = '0;
        if (state_q == ST_PLAY) enter_s = hit_s | tout_s;
        else if (start_press_s) enter_s = '1;
        else                    enter_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rot  = seen ? rotl16(lfsr_q, i) : lfsr_q;
            draw = longint'(OFF_BASE) + (longint'(rot[7:0]) * longint'(OFF_STEP)) / 64'sd256 - 64'sd1;
            rand_last_s[i] = TW'(draw);
            seen = seen | enter_s[i];
        end
    end

    // Free-running Galois LFSR and per-channel latched down-time
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            lfsr_q <= 16'hACE1;
            for (int i = 0; i < NUM_CH; i++) off_q[i] <= TW'(OFF_BASE + i * OFF_STEP - 1);
        end else begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            for (int i = 0; i < NUM_CH; i++) begin
                if (enter_s[i]) off_q[i] <= rand_last_s[i];
                else            off_q[i] <= off_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) off_last_s[i] = off_q[i];
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) off_last_s[i] = TW'(OFF_BASE + i * OFF_STEP - 1);
    end
`endif

    // Per-channel events; a press on an UP channel beats a same-cycle timeout
    always_comb begin
        hit_s  = '0;
        tout_s = '0;
        rise_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mole_q[i]) begin
                if (btn_press_s[i])                        hit_s[i]  = 1'b1;
                else if (timer_q[i] == TW'(ON_CYCLES - 1)) tout_s[i] = 1'b1;
                else                                       hit_s[i]  = 1'b0;
            end else begin
                if (timer_q[i] == off_last_s[i]) rise_s[i] = 1'b1;
                else                             rise_s[i] = 1'b0;
            end
        end
    end

    // Saturating score and clamped miss count for this cycle's events
    always_comb begin
        score_sum_s = {{CW{1'b0}}, score_q} + SW2'(popcount(hit_s));
        miss_sum_s  = {{CW{1'b0}}, miss_q} + SW2'(popcount(tout_s));
        if (score_sum_s[SW2-1:SCORE_W] != '0) score_d = '1;
        else                                  score_d = score_sum_s[SCORE_W-1:0];
        if (miss_sum_s >= SW2'(MISS_LIMIT)) miss_d = SCORE_W'(MISS_LIMIT);
        else                                miss_d = miss_sum_s[SCORE_W-1:0];
    end

    // Game FSM, channel timers and all registered outputs
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q     <= ST_IDLE;
            mole_q      <= '0;
            score_q     <= '0;
            miss_q      <= '0;
            in_game_q   <= 1'b0;
            game_over_q <= 1'b0;
            led_q       <= 6'b000001;
            for (int i = 0; i < NUM_CH; i++) timer_q[i] <= '0;
        end else begin
            game_over_q <= 1'b0;
            led_q       <= led_onehot(score_q);
            case (state_q)
                ST_PLAY: begin
                    if (miss_q >= SCORE_W'(MISS_LIMIT)) begin
                        state_q     <= ST_OVER;
                        in_game_q   <= 1'b0;
                        game_over_q <= 1'b1;
                        mole_q      <= '0;
                        for (int i = 0; i < NUM_CH; i++) timer_q[i] <= '0;
                    end else begin
                        score_q <= score_d;
                        miss_q  <= miss_d;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (hit_s[i] || tout_s[i]) begin
                                mole_q[i]  <= 1'b0;
                                timer_q[i] <= '0;
                            end else if (rise_s[i]) begin
                                mole_q[i]  <= 1'b1;
                                timer_q[i] <= '0;
                            end else begin
                                timer_q[i] <= timer_q[i] + TW'(1);
                            end
                        end
                    end
                end
                ST_IDLE, ST_OVER: begin
                    if (start_press_s) begin
                        state_q   <= ST_PLAY;
                        in_game_q <= 1'b1;
                        score_q   <= '0;
                        miss_q    <= '0;
                        mole_q    <= '0;
                        for (int i = 0; i < NUM_CH; i++) timer_q[i] <= '0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    in_game_q <= 1'b0;
                    mole_q    <= '0;
                end
            endcase
        end
    end

    assign mole      = mole_q;
    assign score     = score_q;
    assign miss      = miss_q;
    assign in_game   = in_game_q;
    assign game_over = game_over_q;
    assign led_phase = led_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Directed bench for mole_game_core (NUM_CH=4, ON=8, OFF_BASE=20, OFF_STEP=4, MISS_LIMIT=3, DEB=2).
module tb_mole_game_core;
    logic        clk;
    logic        reset;
    logic [3:0]  btn_n;
    logic        start_n;
    logic [3:0]  mole;
    logic [15:0] score;
    logic [15:0] miss;
    logic        in_game;
    logic        game_over;
    logic [5:0]  led_phase;

    int vectors     = 0;
    int miscompares = 0;

    mole_game_core #(
        .NUM_CH(4), .ON_CYCLES(8), .OFF_BASE(20), .OFF_STEP(4),
        .MISS_LIMIT(3), .SCORE_W(16), .DEB_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .start_n(start_n),
        .mole(mole), .score(score), .miss(miss), .in_game(in_game),
        .game_over(game_over), .led_phase(led_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        btn_n   = 4'hF;
        start_n = 1'b1;
        cycles(3);
        chk("rst_mole",      32'(mole),      32'h0);
        chk("rst_score",     32'(score),     32'h0);
        chk("rst_miss",      32'(miss),      32'h0);
        chk("rst_in_game",   32'(in_game),   32'h0);
        chk("rst_game_over", 32'(game_over), 32'h0);
        chk("rst_led",       32'(led_phase), 32'h01);

        reset = 1'b1;
        cycles(3);

        // Start press: PLAY entered 5 edges after the raw edge (call that edge E)
        start_n = 1'b0;
        cycles(4);
        chk("start_not_early", 32'(in_game), 32'h0);
        start_n = 1'b1;
        cycles(1);                                     // E
        chk("play_in_game", 32'(in_game), 32'h1);
        chk("play_score0",  32'(score),   32'h0);
        chk("play_miss0",   32'(miss),    32'h0);
        cycles(19);                                    // E+19
        chk("mole0_not_yet", 32'(mole), 32'h0);
        cycles(1);                                     // E+20
        chk("mole0_rise", 32'(mole), 32'h1);

        // Hit on channel 0
        btn_n = 4'b1110;
        cycles(4);                                     // E+24
        chk("hit0_latency", 32'(score), 32'h0);
        chk("mole1_rise",   32'(mole),  32'h3);
        btn_n = 4'hF;
        cycles(1);                                     // E+25
        chk("hit0_score", 32'(score), 32'h1);
        chk("hit0_mole",  32'(mole),  32'h2);
        cycles(1);                                     // E+26
        chk("hit0_led", 32'(led_phase), 32'h02);

        // Double hit on ch1/ch2; ch1 times out on the same edge (hit wins)
        cycles(1);                                     // E+27
        btn_n = 4'b1001;
        cycles(4);                                     // E+31
        chk("dbl_before_score", 32'(score), 32'h1);
        chk("dbl_before_mole",  32'(mole),  32'h6);
        btn_n = 4'hF;
        cycles(1);                                     // E+32
        chk("dbl_score", 32'(score), 32'h3);
        chk("dbl_miss",  32'(miss),  32'h0);
        chk("dbl_mole",  32'(mole),  32'h8);
        cycles(1);                                     // E+33
        chk("dbl_led", 32'(led_phase), 32'h08);

        // No further presses: misses accumulate to the limit
        cycles(6);                                     // E+39
        chk("miss_before1", 32'(miss), 32'h0);
        cycles(1);                                     // E+40
        chk("miss1",      32'(miss), 32'h1);
        chk("miss1_mole", 32'(mole), 32'h0);
        cycles(13);                                    // E+53
        chk("miss2", 32'(miss), 32'h2);
        cycles(11);                                    // E+64
        chk("miss3",         32'(miss),      32'h3);
        chk("miss3_in_game", 32'(in_game),   32'h1);
        chk("miss3_mole",    32'(mole),      32'h4);
        chk("miss3_go",      32'(game_over), 32'h0);
        cycles(1);                                     // E+65
        chk("over_in_game", 32'(in_game),   32'h0);
        chk("over_pulse",   32'(game_over), 32'h1);
        chk("over_mole",    32'(mole),      32'h0);
        chk("over_score",   32'(score),     32'h3);
        cycles(1);                                     // E+66
        chk("over_pulse_end", 32'(game_over), 32'h0);
        chk("over_miss_hold", 32'(miss),      32'h3);
        chk("over_score_hold",32'(score),     32'h3);

        // Restart from OVER (new entry edge E2)
        start_n = 1'b0;
        cycles(4);                                     // E+70
        start_n = 1'b1;
        cycles(1);                                     // E2
        chk("restart_in_game", 32'(in_game),   32'h1);
        chk("restart_score",   32'(score),     32'h0);
        chk("restart_miss",    32'(miss),      32'h0);
        chk("restart_led_old", 32'(led_phase), 32'h08);

        // Press ch2 while it is down: no effect
        btn_n = 4'b1011;
        cycles(1);                                     // E2+1
        chk("restart_led", 32'(led_phase), 32'h01);
        cycles(3);                                     // E2+4
        btn_n = 4'hF;
        cycles(1);                                     // E2+5
        chk("down_press_score", 32'(score), 32'h0);
        chk("down_press_miss",  32'(miss),  32'h0);
        chk("down_press_mole",  32'(mole),  32'h0);
        cycles(15);                                    // E2+20
        chk("g2_mole0_rise", 32'(mole), 32'h1);
        btn_n = 4'b1110;
        cycles(4);                                     // E2+24
        btn_n = 4'hF;
        cycles(1);                                     // E2+25
        chk("g2_hit_score", 32'(score), 32'h1);
        chk("g2_hit_mole",  32'(mole),  32'h2);
        cycles(3);                                     // E2+28
        chk("g2_mole",  32'(mole),  32'h6);
        chk("g2_miss",  32'(miss),  32'h0);

        // Asynchronous reset mid-game
        reset = 1'b0;
        #1;
        chk("mid_rst_mole",    32'(mole),      32'h0);
        chk("mid_rst_score",   32'(score),     32'h0);
        chk("mid_rst_in_game", 32'(in_game),   32'h0);
        chk("mid_rst_led",     32'(led_phase), 32'h01);
        cycles(2);
        reset = 1'b1;
        cycles(30);
        chk("idle_mole",    32'(mole),    32'h0);
        chk("idle_in_game", 32'(in_game), 32'h0);
        chk("idle_score",   32'(score),   32'h0);
        chk("idle_miss",    32'(miss),    32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
